chacha_qr_seq: RTL and testbench

Multi-cycle ChaCha quarter-round sequencer that drives the packed 2x32-bit xor-rotate ISE datapath.
- Accepts four 64-bit state words, each holding two independent 32-bit lanes (hi = [63:32], lo = [31:0]).
- Performs the eight-step quarter-round, issuing each xor-rotate step as a request on the ISE port.
- Sits on the issuing side of the ISE operand/opcode interface and returns the updated quadruple.

---
 rtl/chacha_pkg.sv | 33 +++
 rtl/chacha_add2x32.sv | 10 +
 rtl/chacha_qr_seq.sv | 92 +++++++++
 tb/tb_chacha_qr_seq.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/chacha_pkg.sv
// chacha_pkg: shared types, step constants and the per-step descriptor table for the quarter-round sequencer.
package chacha_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [2:0] STEP_FIRST = 3'd0;
    localparam logic [2:0] STEP_LAST  = 3'd7;

    localparam logic [1:0] REG_A = 2'd0;
    localparam logic [1:0] REG_B = 2'd1;
    localparam logic [1:0] REG_C = 2'd2;
    localparam logic [1:0] REG_D = 2'd3;

    typedef struct packed {
        logic [1:0] dst;
        logic [1:0] src;
        logic       is_add;
        logic [4:0] rot;
    } step_desc_t;

    // Quarter-round schedule: dst op= src, either a lane add or an xor-rotate by rot.
    localparam step_desc_t STEPS [8] = '{
        '{dst: REG_A, src: REG_B, is_add: 1'b1, rot: 5'd0},
        '{dst: REG_D, src: REG_A, is_add: 1'b0, rot: 5'd16},
        '{dst: REG_C, src: REG_D, is_add: 1'b1, rot: 5'd0},
        '{dst: REG_B, src: REG_C, is_add: 1'b0, rot: 5'd12},
        '{dst: REG_A, src: REG_B, is_add: 1'b1, rot: 5'd0},
        '{dst: REG_D, src: REG_A, is_add: 1'b0, rot: 5'd8},
        '{dst: REG_C, src: REG_D, is_add: 1'b1, rot: 5'd0},
        '{dst: REG_B, src: REG_C, is_add: 1'b0, rot: 5'd7}
    };

endpackage

// File: rtl/chacha_add2x32.sv
// chacha_add2x32: two independent 32-bit lane adds packed in 64 bits, no carry between lanes.
module chacha_add2x32 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] sum
);

    assign sum = {a[63:32] + b[63:32], a[31:0] + b[31:0]};

endmodule

// File: rtl/chacha_qr_seq.sv
// chacha_qr_seq: eight-step ChaCha quarter-round sequencer issuing xor-rotate steps to an external ISE datapath.
module chacha_qr_seq
    import chacha_pkg::*;
(
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_a,
    input  logic [63:0] in_b,
    input  logic [63:0] in_c,
    input  logic [63:0] in_d,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_a,
    output logic [63:0] out_b,
    output logic [63:0] out_c,
    output logic [63:0] out_d,
    output logic [63:0] ise_rs1,
    output logic [63:0] ise_rs2,
    output logic        ise_op_add,
    output logic        ise_op_xorrol_16,
    output logic        ise_op_xorrol_12,
    output logic        ise_op_xorrol_8,
    output logic        ise_op_xorrol_7,
    input  logic [63:0] ise_rd
);

    state_t     state, state_nxt;
    logic [2:0] step;
    logic [63:0] r [4];
    step_desc_t desc;
    logic [63:0] sum;
    logic       run, accept, xr;

    assign desc   = STEPS[step];
    assign run    = state == RUN;
    assign accept = in_valid && in_ready;
    assign xr     = run && !desc.is_add;

    assign out_a = r[REG_A];
    assign out_b = r[REG_B];
    assign out_c = r[REG_C];
    assign out_d = r[REG_D];

    chacha_add2x32 u_add (
        .a   (ise_rs1),
        .b   (ise_rs2),
        .sum (sum)
    );

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = (state == IDLE && in_valid)  ? RUN  :
                    (run && step == STEP_LAST)   ? DONE :
                    (state == DONE && out_ready) ? IDLE : state;
    end

    // ISE operands and opcodes depend only on registered state, so the ISE result is consumed in-cycle.
    always_comb begin
        in_ready         = state == IDLE;
        out_valid        = state == DONE;
        ise_rs1          = run ? r[desc.dst] : '0;
        ise_rs2          = run ? r[desc.src] : '0;
        ise_op_add       = run && desc.is_add;
        ise_op_xorrol_16 = xr && desc.rot == 5'd16;
        ise_op_xorrol_12 = xr && desc.rot == 5'd12;
        ise_op_xorrol_8  = xr && desc.rot == 5'd8;
        ise_op_xorrol_7  = xr && desc.rot == 5'd7;
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            step <= STEP_FIRST;
            r    <= '{default: '0};
        end else if (accept) begin
            step     <= STEP_FIRST;
            r[REG_A] <= in_a;
            r[REG_B] <= in_b;
            r[REG_C] <= in_c;
            r[REG_D] <= in_d;
        end else if (run) begin
            step        <= step + 3'd1;
            r[desc.dst] <= desc.is_add ? sum : ise_rd;
        end
    end

endmodule

// File: tb/tb_chacha_qr_seq.sv
// tb_chacha_qr_seq: randomized and directed checks of the quarter-round sequencer against a per-lane ChaCha model.
module tb_chacha_qr_seq;

    logic        g_clk = 1'b0;
    logic        g_reset = 1'b1;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [63:0] in_a = '0, in_b = '0, in_c = '0, in_d = '0;
    logic [63:0] out_a, out_b, out_c, out_d, ise_rs1, ise_rs2, ise_rd;
    logic        ise_op_add, ise_op_xorrol_16, ise_op_xorrol_12, ise_op_xorrol_8, ise_op_xorrol_7;
    int          tests = 0, fails = 0;

    localparam logic [31:0] RA = 32'h11111111, RB = 32'h01020304, RC = 32'h9b8d6f43, RD = 32'h01234567;
    localparam logic [31:0] QA = 32'hea2a92f4, QB = 32'hcb1cf8ce, QC = 32'h4581472e, QD = 32'h5881c4bb;
    localparam logic [4:0]  OPS [8] = '{5'b10000, 5'b01000, 5'b10000, 5'b00100,
                                        5'b10000, 5'b00010, 5'b10000, 5'b00001};

    chacha_qr_seq dut (
        .g_clk(g_clk), .g_reset(g_reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
        .ise_rs1(ise_rs1), .ise_rs2(ise_rs2), .ise_op_add(ise_op_add),
        .ise_op_xorrol_16(ise_op_xorrol_16), .ise_op_xorrol_12(ise_op_xorrol_12),
        .ise_op_xorrol_8(ise_op_xorrol_8), .ise_op_xorrol_7(ise_op_xorrol_7), .ise_rd(ise_rd)
    );

    always #5 g_clk = ~g_clk;

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // External ISE datapath: per-lane rol(rs1 ^ rs2, n).
    int          ise_n;
    logic [63:0] ise_x;
    always_comb begin
        ise_n  = ise_op_xorrol_16 ? 16 : ise_op_xorrol_12 ? 12 : ise_op_xorrol_8 ? 8 : ise_op_xorrol_7 ? 7 : 0;
        ise_x  = ise_rs1 ^ ise_rs2;
        ise_rd = {rol(ise_x[63:32], ise_n), rol(ise_x[31:0], ise_n)};
    end

    task automatic model(input logic [63:0] a, b, c, d, output logic [63:0] ea, eb, ec, ed);
        logic [31:0] x, y, z, w;
        for (int l = 0; l < 2; l++) begin
            x = a[32*l +: 32]; y = b[32*l +: 32]; z = c[32*l +: 32]; w = d[32*l +: 32];
            x = x + y; w = rol(w ^ x, 16);
            z = z + w; y = rol(y ^ z, 12);
            x = x + y; w = rol(w ^ x, 8);
            z = z + w; y = rol(y ^ z, 7);
            ea[32*l +: 32] = x; eb[32*l +: 32] = y; ec[32*l +: 32] = z; ed[32*l +: 32] = w;
        end
    endtask

    function automatic logic [132:0] ise_all();
        return {ise_rs1, ise_rs2, ise_op_add, ise_op_xorrol_16, ise_op_xorrol_12, ise_op_xorrol_8, ise_op_xorrol_7};
    endfunction

    task automatic accept(input logic [63:0] a, b, c, d);
        @(negedge g_clk);
        in_a = a; in_b = b; in_c = c; in_d = d; in_valid = 1'b1;
        for (int i = 0; i < 30 && in_ready !== 1'b1; i++) @(negedge g_clk);
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL accept_wait: in_ready=%b required 1", in_ready); end
        @(posedge g_clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_check(input logic [63:0] a, b, c, d, input string name, input bit toggle, input int hold,
                             output logic [63:0] ra, rb, rc, rd);
        logic [63:0] e [4];
        logic [63:0] g [4];
        model(a, b, c, d, e[0], e[1], e[2], e[3]);
        out_ready = 1'b0;
        accept(a, b, c, d);
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                fails++; $display("FAIL %s run_flags step %0d: valid=%b ready=%b required 0 0", name, k, out_valid, in_ready);
            end
            tests++;
            if ({ise_op_add, ise_op_xorrol_16, ise_op_xorrol_12, ise_op_xorrol_8, ise_op_xorrol_7} !== OPS[k]) begin
                fails++;
                $display("FAIL %s op_trace step %0d: got %b required %b", name, k,
                         {ise_op_add, ise_op_xorrol_16, ise_op_xorrol_12, ise_op_xorrol_8, ise_op_xorrol_7}, OPS[k]);
            end
            if (toggle) begin
                in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
                in_c = {$urandom, $urandom}; in_d = {$urandom, $urandom}; in_valid = 1'($urandom);
            end
            @(posedge g_clk); #1;
        end
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            fails++; $display("FAIL %s latency: valid=%b ready=%b required 1 0", name, out_valid, in_ready);
        end
        tests++;
        if (ise_all() !== '0) begin fails++; $display("FAIL %s ise_done: got %h required 0", name, ise_all()); end
        g = '{out_a, out_b, out_c, out_d};
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (g[i] !== e[i]) begin fails++; $display("FAIL %s out[%0d]: got %h required %h", name, i, g[i], e[i]); end
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge g_clk); #1;
            tests++;
            if ({out_valid, in_ready, out_a, out_b, out_c, out_d} !== {1'b1, 1'b0, e[0], e[1], e[2], e[3]} || ise_all() !== '0) begin
                fails++; $display("FAIL %s backpressure cycle %0d: valid=%b ready=%b a=%h required a=%h", name, h, out_valid, in_ready, out_a, e[0]);
            end
        end
        out_ready = 1'b1;
        @(posedge g_clk); #1;
        out_ready = 1'b0;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++; $display("FAIL %s release: ready=%b valid=%b required 1 0", name, in_ready, out_valid);
        end
        {ra, rb, rc, rd} = {g[0], g[1], g[2], g[3]};
    endtask

    task automatic test_reset();
        repeat (2) @(posedge g_clk);
        #1;
        tests++;
        if ({in_ready, out_valid, out_a, out_b, out_c, out_d} !== {1'b1, 257'b0} || ise_all() !== '0) begin
            fails++; $display("FAIL reset_state: ready=%b valid=%b a=%h ise=%h required 1 0 0 0", in_ready, out_valid, out_a, ise_all());
        end
        @(negedge g_clk);
        g_reset = 1'b0;
    endtask

    task automatic test_rfc();
        logic [63:0] a, b, c, d;
        run_check({32'h0, RA}, {32'h0, RB}, {32'h0, RC}, {32'h0, RD}, "rfc_lo", 1'b0, 0, a, b, c, d);
        tests++;
        if ({a, b, c, d} !== {32'h0, QA, 32'h0, QB, 32'h0, QC, 32'h0, QD}) begin
            fails++; $display("FAIL rfc_lo_vector: got %h %h %h %h", a, b, c, d);
        end
        run_check({RA, 32'h0}, {RB, 32'h0}, {RC, 32'h0}, {RD, 32'h0}, "rfc_hi", 1'b0, 0, a, b, c, d);
        tests++;
        if ({a, b, c, d} !== {QA, 32'h0, QB, 32'h0, QC, 32'h0, QD, 32'h0}) begin
            fails++; $display("FAIL rfc_hi_vector: got %h %h %h %h", a, b, c, d);
        end
        run_check({RA, RA}, {RB, RB}, {RC, RC}, {RD, RD}, "rfc_both", 1'b0, 0, a, b, c, d);
        tests++;
        if ({a, b, c, d} !== {QA, QA, QB, QB, QC, QC, QD, QD}) begin
            fails++; $display("FAIL rfc_both_vector: got %h %h %h %h", a, b, c, d);
        end
    endtask

    task automatic test_lane_carry();
        logic [63:0] a, b, c, d;
        out_ready = 1'b0;
        accept({32'h12345678, 32'hffffffff}, {32'h0, 32'h1}, 64'h0, 64'h0);
        @(posedge g_clk); #1;
        tests++;
        if (out_a !== {32'h12345678, 32'h0}) begin
            fails++; $display("FAIL lane_carry: got %h required %h", out_a, {32'h12345678, 32'h0});
        end
        for (int i = 0; i < 20 && out_valid !== 1'b1; i++) @(posedge g_clk);
        @(negedge g_clk);
        out_ready = 1'b1;
        @(posedge g_clk); #1;
        out_ready = 1'b0;
        run_check({32'h12345678, 32'hffffffff}, {32'h0, 32'h1}, {32'hdeadbeef, 32'hffffffff}, {32'hffffffff, 32'h1},
                  "lane_carry_full", 1'b0, 0, a, b, c, d);
    endtask

    task automatic test_backpressure();
        logic [63:0] a, b, c, d;
        run_check({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                  "backpressure", 1'b0, 20, a, b, c, d);
    endtask

    task automatic test_random_toggle();
        logic [63:0] a, b, c, d;
        for (int n = 0; n < 6; n++)
            run_check({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                      "random_toggle", 1'b1, int'($urandom_range(0, 3)), a, b, c, d);
    endtask

    task automatic test_reset_mid_run();
        logic [63:0] a, b, c, d;
        out_ready = 1'b0;
        accept({RA, RA}, {RB, RB}, {RC, RC}, {RD, RD});
        repeat (4) @(posedge g_clk);
        #2;
        g_reset = 1'b1;
        #1;
        tests++;
        if ({in_ready, out_valid, out_a, out_b, out_c, out_d} !== {1'b1, 257'b0} || ise_all() !== '0) begin
            fails++; $display("FAIL reset_mid_run: ready=%b valid=%b a=%h ise=%h required 1 0 0 0", in_ready, out_valid, out_a, ise_all());
        end
        @(negedge g_clk);
        g_reset = 1'b0;
        run_check({32'h0, RA}, {32'h0, RB}, {32'h0, RC}, {32'h0, RD}, "after_reset", 1'b0, 0, a, b, c, d);
        tests++;
        if ({a[31:0], b[31:0], c[31:0], d[31:0]} !== {QA, QB, QC, QD}) begin
            fails++; $display("FAIL after_reset_vector: got %h %h %h %h", a, b, c, d);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] v [4];
        logic [63:0] e [4];
        int first = -1, second = -1;
        bit checked = 1'b0;
        v = '{{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}};
        model(v[0], v[1], v[2], v[3], e[0], e[1], e[2], e[3]);
        @(negedge g_clk);
        {in_a, in_b, in_c, in_d} = {v[0], v[1], v[2], v[3]};
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 40 && second < 0; i++) begin
            if (in_ready === 1'b1) begin
                if (first < 0) first = i; else second = i;
            end
            if (out_valid === 1'b1 && !checked) begin
                checked = 1'b1;
                tests++;
                if ({out_a, out_b, out_c, out_d} !== {e[0], e[1], e[2], e[3]}) begin
                    fails++; $display("FAIL b2b_result: got a=%h required a=%h", out_a, e[0]);
                end
            end
            @(negedge g_clk);
        end
        in_valid = 1'b0;
        tests++;
        if (second - first !== 10) begin
            fails++; $display("FAIL b2b_spacing: got %0d required 10", second - first);
        end
        for (int i = 0; i < 30 && in_ready !== 1'b1; i++) @(negedge g_clk);
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_drain: in_ready=%b required 1", in_ready); end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rfc();
        test_lane_carry();
        test_backpressure();
        test_random_toggle();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
